addr_trans_pipe: RTL and testbench
==================================

Name: addr_trans_pipe

Overview:
- Parametrised, registered virtual-to-physical address translator for the LoongArch-style core.
- Serves N_CH independent request channels (default ch0 = instruction fetch, ch1 = load/store), each through a one-entry valid/ready pipeline stage.
- Supports direct-address (DA) mode and mapped mode with N_DMW direct-mapped windows checked against the current privilege level.
- Signals a window miss per request; the TLB is not in this block and handles the miss downstream.

Parameters:
- N_CH, 2, number of translation channels.
- N_DMW, 2, number of DMW CSRs checked; lowest index has priority on multiple hits.
- FETCH_MASK, 2'b01, width N_CH; bit i set selects crmd_datf as the DA-mode memory type for channel i, otherwise crmd_datm.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  pipeline flush (excp/ertn/branch, pre-ORed)
- crmd_da  in  1  CRMD.DA
- crmd_pg  in  1  CRMD.PG
- crmd_plv  in  2  CRMD.PLV
- crmd_datf  in  2  DA-mode MAT for fetch channels
- crmd_datm  in  2  DA-mode MAT for data channels
- dmw  in  N_DMW*32  packed DMW CSRs; each word is [0]=PLV0 enable, [3]=PLV3 enable, [5:4]=MAT, [27:25]=PSEG, [31:29]=VSEG
- in_vaddr  in  N_CH*32  request virtual addresses
- in_valid  in  N_CH  request valid
- in_ready  out  N_CH  request accepted
- out_paddr  out  N_CH*32  translated physical address
- out_uncached  out  N_CH  memory type is strongly-ordered uncached (MAT==0)
- out_miss  out  N_CH  mapped mode with no DMW hit
- out_valid  out  N_CH  result valid
- out_ready  in  N_CH  consumer ready

Behaviour:
- Reset (async): out_valid=0, out_paddr=0, out_uncached=0, out_miss=0 on all channels.
- Channels are fully independent; there is no shared arbitration.
- Per channel i: in_ready[i] = !flush && (!out_valid[i] || out_ready[i]).
  - Accept when in_valid && in_ready. The result registers at the next edge: latency 1, throughput 1 per cycle.
  - If out_valid && !out_ready && !flush, the stage holds and all outputs stay stable.
  - If no accept occurs and out_ready is high, out_valid drops to 0.
- Flush:
  - The cycle flush is high, every out_valid clears at the next edge.
  - No request is accepted in that cycle (in_ready=0).
  - Flush has priority over a simultaneous handshake.
- CSR inputs are sampled in the accept cycle. A CSR change while a result is held does not alter that result.
- Mode selection:
  - crmd_da=1 (regardless of PG), or da=0 with pg=0: direct. paddr=vaddr, miss=0. MAT is crmd_datf if FETCH_MASK[i], else crmd_datm.
  - da=0, pg=1: mapped.
    - DMW k hits when vaddr[31:29]==dmw_k[31:29] AND ((plv==0 && dmw_k[0]) || (plv==3 && dmw_k[3])).
    - plv 1 and 2 never hit.
    - On a hit, the first hitting k gives paddr={dmw_k[27:25], vaddr[28:0]}, MAT=dmw_k[5:4], miss=0.
    - With no hit: paddr=vaddr, miss=1, uncached=0.
- uncached = (MAT==2'b00); MAT values 1 and 2/3 are treated as cached.
- Reset mid-transfer drops held results without reporting them.

Optional Feature:
- Macro ADDR_TRANS_PIPE_MISS_CNT_EN.
- Defined:
  - Adds output port miss_cnt (N_CH*32): per-channel 32-bit counter.
  - The counter increments on each accepted request that produces out_miss=1.
  - It saturates at 32'hFFFF_FFFF and clears on reset only (not on flush).
  - Flushed-away misses still count.
- Undefined: the port and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package: DMW field bit-position constants (PLV0, PLV3, MAT lo/hi, PSEG lo/hi, VSEG lo/hi), MAT encoding constants (MAT_SUC=2'b00, MAT_CC=2'b01), and a translation-result struct {paddr, uncached, miss}.
- One sub-module, dmw_lookup: combinational single-channel lookup (vaddr + CSRs -> result struct), instantiated N_CH times under generate.
- The top level holds the pipeline registers, handshake logic and the optional counters.

Test Plan:
- DA mode: da=1, datm=0, datf=1; ch0 vaddr 0x1C00_0000, ch1 vaddr 0xBFD0_0000 -> next cycle paddr equals vaddr; ch0 uncached=0, ch1 uncached=1; miss=0.
- Mapped hit: pg=1, da=0, plv=0, dmw0=0x9000_0011 (VSEG 4, PSEG 0, MAT 1, PLV0); vaddr 0x8000_1234 -> paddr 0x0000_1234, uncached=0, miss=0.
- Window priority and privilege:
  - dmw0=0x8000_0001 and dmw1=0x8000_0009 (both VSEG 4); plv=0; vaddr 0x8000_0040 -> dmw0 wins, uncached=1.
  - plv=3 on the same address -> only dmw1 hits, uncached=1.
  - plv=1 -> miss=1, paddr=0x8000_0040.
- Backpressure: out_ready=0 for 3 cycles with in_valid held -> in_ready=0 and outputs stable; CSRs changed meanwhile do not alter the held result; out_ready=1 -> next request issues one cycle later.
- Flush: flush asserted with a held result and a pending request -> out_valid=0 next cycle, no accept; assert reset mid-stream -> all outputs zero immediately (async).
- With ADDR_TRANS_PIPE_MISS_CNT_EN defined: 5 mapped misses on ch1, one of them flushed -> miss_cnt[ch1]=5, miss_cnt[ch0]=0.

Source files
------------

// File: rtl/addr_trans_pipe_pkg.sv
// ---------------------------------------------------------------------------
// addr_trans_pipe_pkg
//   Shared definitions for the address translation pipeline:
//   - bit positions of the fields inside one 32-bit DMW CSR word
//   - memory-access-type (MAT) encodings
//   - the per-request translation result carried through the pipeline
// ---------------------------------------------------------------------------
package addr_trans_pipe_pkg;

    // DMW CSR field positions
    localparam int DMW_PLV0    = 0;
    localparam int DMW_PLV3    = 3;
    localparam int DMW_MAT_LO  = 4;
    localparam int DMW_MAT_HI  = 5;
    localparam int DMW_PSEG_LO = 25;
    localparam int DMW_PSEG_HI = 27;
    localparam int DMW_VSEG_LO = 29;
    localparam int DMW_VSEG_HI = 31;

    // Memory access types
    localparam logic [1:0] MAT_SUC = 2'b00;  // strongly-ordered uncached
    localparam logic [1:0] MAT_CC  = 2'b01;  // coherent cached

    typedef struct packed {
        logic [31:0] paddr;
        logic        uncached;
        logic        miss;
    } trans_res_t;

endpackage

// File: rtl/addr_trans_pipe_dmw_lookup.sv
// ---------------------------------------------------------------------------
// dmw_lookup
//   Combinational single-channel translation: direct-address mode or a
//   search of the direct-mapped windows against the current privilege level.
//
//   Ports:
//     vaddr_i      [31:0]        virtual address
//     crmd_da_i                  CRMD.DA
//     crmd_pg_i                  CRMD.PG
//     crmd_plv_i   [1:0]         CRMD.PLV
//     crmd_datf_i  [1:0]         DA-mode MAT for fetch channels
//     crmd_datm_i  [1:0]         DA-mode MAT for data channels
//     dmw_i        [N_DMW*32-1:0] packed DMW CSRs, window 0 in the low word
//     res_o                      translation result {paddr, uncached, miss}
// ---------------------------------------------------------------------------
module dmw_lookup
    import addr_trans_pipe_pkg::*;
#(
    parameter int N_DMW    = 2,
    parameter bit IS_FETCH = 1'b0
) (
    input  logic [31:0]        vaddr_i,
    input  logic               crmd_da_i,
    input  logic               crmd_pg_i,
    input  logic [1:0]         crmd_plv_i,
    input  logic [1:0]         crmd_datf_i,
    input  logic [1:0]         crmd_datm_i,
    input  logic [N_DMW*32-1:0] dmw_i,
    output trans_res_t         res_o
);

    logic [31:0] win;
    logic [1:0]  mat;
    logic        hit;

    // Only some DMW bits are meaningful; fold the whole vector here so the
    // reserved bits are visibly consumed.
    logic unused_dmw;
    assign unused_dmw = ^dmw_i;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // through this block can infer a latch.
        res_o.paddr    = vaddr_i;
        res_o.uncached = 1'b0;
        res_o.miss     = 1'b0;
        win            = '0;
        hit            = 1'b0;
        // A cached default makes "no window hit" report uncached=0.
        mat            = MAT_CC;

        if (crmd_da_i || !crmd_pg_i) begin
            mat = IS_FETCH ? crmd_datf_i : crmd_datm_i;
        end else begin
            // Walk from the highest window down so the lowest hitting
            // index is the last to write and therefore wins.
            for (int k = N_DMW - 1; k >= 0; k--) begin
                win = dmw_i[k*32 +: 32];
                if ((win[DMW_VSEG_HI:DMW_VSEG_LO] == vaddr_i[DMW_VSEG_HI:DMW_VSEG_LO]) &&
                    (((crmd_plv_i == 2'd0) && win[DMW_PLV0]) ||
                     ((crmd_plv_i == 2'd3) && win[DMW_PLV3]))) begin
                    hit         = 1'b1;
                    res_o.paddr = {win[DMW_PSEG_HI:DMW_PSEG_LO], vaddr_i[DMW_VSEG_LO-1:0]};
                    mat         = win[DMW_MAT_HI:DMW_MAT_LO];
                end
            end
            res_o.miss = !hit;
        end

        res_o.uncached = (mat == MAT_SUC);
    end

endmodule

// File: rtl/addr_trans_pipe.sv
// ---------------------------------------------------------------------------
// addr_trans_pipe
//   Registered virtual-to-physical address translator with N_CH independent
//   channels, each a one-entry valid/ready stage (latency 1, throughput 1).
//   A window miss in mapped mode is flagged; the TLB resolves it downstream.
//
//   Optional feature macro: ADDR_TRANS_PIPE_MISS_CNT_EN
//     Adds output miss_cnt with a saturating 32-bit per-channel count of
//     accepted requests that missed every window (cleared only by reset).
//
//   Ports:
//     clk, reset (async, active high)
//     flush                      drops held results, blocks accepts
//     crmd_da/pg/plv/datf/datm   CRMD fields
//     dmw       [N_DMW*32-1:0]   packed DMW CSRs
//     in_vaddr  [N_CH*32-1:0]    request addresses, in_valid/in_ready
//     out_paddr [N_CH*32-1:0]    results with out_uncached/out_miss,
//                                out_valid/out_ready
//     miss_cnt  [N_CH*32-1:0]    (macro only) per-channel miss counters
// ---------------------------------------------------------------------------
module addr_trans_pipe
    import addr_trans_pipe_pkg::*;
#(
    parameter int              N_CH       = 2,
    parameter int              N_DMW      = 2,
    parameter logic [N_CH-1:0] FETCH_MASK = 2'b01
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                crmd_da,
    input  logic                crmd_pg,
    input  logic [1:0]          crmd_plv,
    input  logic [1:0]          crmd_datf,
    input  logic [1:0]          crmd_datm,
    input  logic [N_DMW*32-1:0] dmw,
    input  logic [N_CH*32-1:0]  in_vaddr,
    input  logic [N_CH-1:0]     in_valid,
    output logic [N_CH-1:0]     in_ready,
    output logic [N_CH*32-1:0]  out_paddr,
    output logic [N_CH-1:0]     out_uncached,
    output logic [N_CH-1:0]     out_miss,
    output logic [N_CH-1:0]     out_valid,
    input  logic [N_CH-1:0]     out_ready
`ifdef ADDR_TRANS_PIPE_MISS_CNT_EN
    ,
    output logic [N_CH*32-1:0]  miss_cnt
`endif
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        trans_res_t lkp_res;
        trans_res_t res_q, res_d;
        logic       valid_q, valid_d;
        logic       accept;

        dmw_lookup #(
            .N_DMW    (N_DMW),
            .IS_FETCH (FETCH_MASK[i])
        ) u_lookup (
            .vaddr_i     (in_vaddr[i*32 +: 32]),
            .crmd_da_i   (crmd_da),
            .crmd_pg_i   (crmd_pg),
            .crmd_plv_i  (crmd_plv),
            .crmd_datf_i (crmd_datf),
            .crmd_datm_i (crmd_datm),
            .dmw_i       (dmw),
            .res_o       (lkp_res)
        );

        assign in_ready[i] = !flush && (!valid_q || out_ready[i]);
        assign accept      = in_valid[i] && in_ready[i];

        // CSRs are only sampled through lkp_res on accept, so a held
        // result is immune to later CSR writes.
        always_comb begin
            valid_d = valid_q;
            res_d   = res_q;
            if (flush) begin
                valid_d = 1'b0;
            end else if (accept) begin
                valid_d = 1'b1;
                res_d   = lkp_res;
            end else if (out_ready[i]) begin
                valid_d = 1'b0;
            end
        end

        // NOTE: clocked state uses non-blocking assignments so every
        // register samples pre-edge values regardless of evaluation order.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                valid_q <= 1'b0;
                // NOTE: the result register is reset as well because it
                // drives the outputs directly and they must read zero.
                res_q   <= '0;
            end else begin
                valid_q <= valid_d;
                res_q   <= res_d;
            end
        end

        assign out_valid[i]          = valid_q;
        assign out_paddr[i*32 +: 32] = res_q.paddr;
        assign out_uncached[i]       = res_q.uncached;
        assign out_miss[i]           = res_q.miss;

`ifdef ADDR_TRANS_PIPE_MISS_CNT_EN
        logic [31:0] miss_cnt_q, miss_cnt_d;

        // Counted at accept, so a miss later dropped by flush still counts.
        always_comb begin
            miss_cnt_d = miss_cnt_q;
            if (accept && lkp_res.miss && (miss_cnt_q != 32'hFFFF_FFFF)) begin
                miss_cnt_d = miss_cnt_q + 32'd1;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                miss_cnt_q <= '0;
            end else begin
                miss_cnt_q <= miss_cnt_d;
            end
        end

        assign miss_cnt[i*32 +: 32] = miss_cnt_q;
`endif
    end

endmodule

// File: tb/tb_addr_trans_pipe.sv
// ---------------------------------------------------------------------------
// tb_addr_trans_pipe
//   Directed self-checking bench for addr_trans_pipe. Expected results come
//   from a behavioural translation model and are queued per channel on
//   accept, then compared while the DUT presents them.
//   Honours ADDR_TRANS_PIPE_MISS_CNT_EN for the optional miss counters.
// ---------------------------------------------------------------------------
module tb_addr_trans_pipe;

    localparam int         N_CH       = 2;
    localparam int         N_DMW      = 2;
    localparam logic [1:0] FETCH_MASK = 2'b01;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        crmd_da;
    logic        crmd_pg;
    logic [1:0]  crmd_plv;
    logic [1:0]  crmd_datf;
    logic [1:0]  crmd_datm;
    logic [63:0] dmw;
    logic [63:0] in_vaddr;
    logic [1:0]  in_valid;
    logic [1:0]  in_ready;
    logic [63:0] out_paddr;
    logic [1:0]  out_uncached;
    logic [1:0]  out_miss;
    logic [1:0]  out_valid;
    logic [1:0]  out_ready;
`ifdef ADDR_TRANS_PIPE_MISS_CNT_EN
    logic [63:0] miss_cnt;
`endif

    always #5 clk = ~clk;

    addr_trans_pipe #(
        .N_CH       (N_CH),
        .N_DMW      (N_DMW),
        .FETCH_MASK (FETCH_MASK)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .crmd_da      (crmd_da),
        .crmd_pg      (crmd_pg),
        .crmd_plv     (crmd_plv),
        .crmd_datf    (crmd_datf),
        .crmd_datm    (crmd_datm),
        .dmw          (dmw),
        .in_vaddr     (in_vaddr),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_paddr    (out_paddr),
        .out_uncached (out_uncached),
        .out_miss     (out_miss),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
`ifdef ADDR_TRANS_PIPE_MISS_CNT_EN
        ,
        .miss_cnt     (miss_cnt)
`endif
    );

    int          n_vec  = 0;
    int          n_fail = 0;
    logic [1:0]  m_valid;
    logic [33:0] sb_q [2][$];   // {paddr, uncached, miss}
    logic [31:0] m_cnt [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Behavioural model of one translation using the current CSR inputs.
    function automatic logic [33:0] ref_xlate(input int c, input logic [31:0] va);
        logic [1:0]  fm;
        logic [1:0]  mat;
        logic [31:0] w;
        fm = FETCH_MASK;
        if (crmd_da || !crmd_pg) begin
            mat = fm[c] ? crmd_datf : crmd_datm;
            return {va, (mat == 2'b00), 1'b0};
        end
        for (int k = 0; k < N_DMW; k++) begin
            w = dmw[k*32 +: 32];
            if (w[31:29] == va[31:29] &&
                ((crmd_plv == 2'd0 && w[0]) || (crmd_plv == 2'd3 && w[3])))
                return {w[27:25], va[28:0], (w[5:4] == 2'b00), 1'b0};
        end
        return {va, 1'b0, 1'b1};
    endfunction

    // One clock: called at posedge+1 with inputs already driven. Checks at
    // the negedge, updates the model, and returns at the next posedge+1.
    task automatic tick();
        logic [33:0] exp_r;
        logic        rdy;
        logic        acc;
        #4;
        for (int c = 0; c < 2; c++) begin
            rdy = !flush && (!m_valid[c] || out_ready[c]);
            check($sformatf("in_ready_ch%0d", c), in_ready[c], rdy);
            check($sformatf("out_valid_ch%0d", c), out_valid[c], m_valid[c]);
`ifdef ADDR_TRANS_PIPE_MISS_CNT_EN
            check($sformatf("miss_cnt_ch%0d", c), miss_cnt[c*32 +: 32], m_cnt[c]);
`endif
            if (m_valid[c]) begin
                check($sformatf("sb_nonempty_ch%0d", c), (sb_q[c].size() > 0), 1'b1);
                if (sb_q[c].size() > 0) begin
                    exp_r = sb_q[c][0];
                    check($sformatf("paddr_ch%0d", c), out_paddr[c*32 +: 32], exp_r[33:2]);
                    check($sformatf("uncached_ch%0d", c), out_uncached[c], exp_r[1]);
                    check($sformatf("miss_ch%0d", c), out_miss[c], exp_r[0]);
                    if (flush || out_ready[c]) void'(sb_q[c].pop_front());
                end
            end
            acc = in_valid[c] && rdy;
            if (acc) begin
                exp_r = ref_xlate(c, in_vaddr[c*32 +: 32]);
                sb_q[c].push_back(exp_r);
                if (exp_r[0] && m_cnt[c] != 32'hFFFF_FFFF) m_cnt[c] = m_cnt[c] + 32'd1;
            end
            if (flush)             m_valid[c] = 1'b0;
            else if (acc)          m_valid[c] = 1'b1;
            else if (out_ready[c]) m_valid[c] = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input int c, input logic [31:0] pa, input logic unc, input logic miss);
        check($sformatf("exp_valid_ch%0d", c), out_valid[c], 1'b1);
        check($sformatf("exp_paddr_ch%0d", c), out_paddr[c*32 +: 32], pa);
        check($sformatf("exp_uncached_ch%0d", c), out_uncached[c], unc);
        check($sformatf("exp_miss_ch%0d", c), out_miss[c], miss);
    endtask

    task automatic check_reset_zero();
        check("rst_out_valid", out_valid, 2'b00);
        check("rst_paddr_lo", out_paddr[31:0], 32'h0);
        check("rst_paddr_hi", out_paddr[63:32], 32'h0);
        check("rst_uncached", out_uncached, 2'b00);
        check("rst_miss", out_miss, 2'b00);
`ifdef ADDR_TRANS_PIPE_MISS_CNT_EN
        check("rst_cnt_ch0", miss_cnt[31:0], 32'h0);
        check("rst_cnt_ch1", miss_cnt[63:32], 32'h0);
`endif
    endtask

    task automatic model_reset();
        m_valid = 2'b00;
        for (int c = 0; c < 2; c++) begin
            sb_q[c].delete();
            m_cnt[c] = 32'h0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        crmd_da   = 1'b0;
        crmd_pg   = 1'b0;
        crmd_plv  = 2'd0;
        crmd_datf = 2'd0;
        crmd_datm = 2'd0;
        dmw       = 64'h0;
        in_vaddr  = 64'h0;
        in_valid  = 2'b00;
        out_ready = 2'b11;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_reset_zero();
        reset = 1'b0;

        // Direct-address mode: ch0 fetch uses datf (cached), ch1 uses datm (SUC)
        crmd_da   = 1'b1;
        crmd_datm = 2'd0;
        crmd_datf = 2'd1;
        in_vaddr  = {32'hBFD0_0000, 32'h1C00_0000};
        in_valid  = 2'b11;
        tick();
        in_valid  = 2'b00;
        expect_out(0, 32'h1C00_0000, 1'b0, 1'b0);
        expect_out(1, 32'hBFD0_0000, 1'b1, 1'b0);
        tick();

        // Mapped hit through dmw0 (VSEG 4 -> PSEG 0, MAT CC)
        crmd_da  = 1'b0;
        crmd_pg  = 1'b1;
        crmd_plv = 2'd0;
        dmw      = {32'h0000_0000, 32'h9000_0011};
        in_vaddr = {32'h0, 32'h8000_1234};
        in_valid = 2'b01;
        tick();
        in_valid = 2'b00;
        expect_out(0, 32'h0000_1234, 1'b0, 1'b0);
        tick();

        // Window priority and privilege, back-to-back on ch0
        dmw      = {32'h8000_0009, 32'h8000_0001};
        in_vaddr = {32'h0, 32'h8000_0040};
        in_valid = 2'b01;
        crmd_plv = 2'd0;
        tick();
        expect_out(0, 32'h0000_0040, 1'b1, 1'b0);
        crmd_plv = 2'd3;
        tick();
        expect_out(0, 32'h0000_0040, 1'b1, 1'b0);
        crmd_plv = 2'd1;
        tick();
        expect_out(0, 32'h8000_0040, 1'b0, 1'b1);
        crmd_plv = 2'd2;
        tick();
        expect_out(0, 32'h8000_0040, 1'b0, 1'b1);
        // Distinct windows: dmw1 maps to PSEG 5, MAT CC, both PLVs enabled
        dmw      = {32'h8A00_0019, 32'h8000_0001};
        crmd_plv = 2'd0;
        tick();
        expect_out(0, 32'h0000_0040, 1'b1, 1'b0);
        crmd_plv = 2'd3;
        tick();
        expect_out(0, 32'hA000_0040, 1'b0, 1'b0);
        crmd_plv = 2'd0;
        in_vaddr = {32'h0, 32'hA000_0040};
        tick();
        expect_out(0, 32'hA000_0040, 1'b0, 1'b1);
        in_valid = 2'b00;
        tick();

        // Backpressure on ch1 with CSR change while held
        dmw       = {32'h0000_0000, 32'h9000_0011};
        out_ready = 2'b01;
        in_vaddr  = {32'h8000_2000, 32'h0};
        in_valid  = 2'b10;
        tick();
        in_vaddr  = {32'h8000_3000, 32'h0};
        tick();
        expect_out(1, 32'h0000_2000, 1'b0, 1'b0);
        tick();
        expect_out(1, 32'h0000_2000, 1'b0, 1'b0);
        dmw       = {32'h0000_0000, 32'h9200_0001};
        tick();
        expect_out(1, 32'h0000_2000, 1'b0, 1'b0);
        out_ready = 2'b11;
        tick();
        expect_out(1, 32'h2000_3000, 1'b1, 1'b0);
        in_valid  = 2'b00;
        tick();

        // Flush with a held result and a pending request on ch0
        out_ready = 2'b10;
        in_vaddr  = {32'h0, 32'h8000_4000};
        in_valid  = 2'b01;
        tick();
        expect_out(0, 32'h2000_4000, 1'b1, 1'b0);
        in_vaddr  = {32'h0, 32'h8000_5000};
        flush     = 1'b1;
        tick();
        flush     = 1'b0;
        in_valid  = 2'b00;
        check("flush_clears_valid", out_valid[0], 1'b0);
        out_ready = 2'b11;
        tick();

        // Asynchronous reset mid-stream with results held on both channels
        out_ready = 2'b00;
        in_vaddr  = {32'h8000_6000, 32'h8000_7000};
        in_valid  = 2'b11;
        tick();
        tick();
        reset = 1'b1;
        #1;
        check_reset_zero();
        model_reset();
        in_valid  = 2'b00;
        out_ready = 2'b11;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Five mapped misses on ch1 (plv 1 never hits), the last one flushed
        crmd_da  = 1'b0;
        crmd_pg  = 1'b1;
        crmd_plv = 2'd1;
        in_valid = 2'b10;
        for (int k = 0; k < 5; k++) begin
            in_vaddr = {32'h8000_0000 + 32'(k * 4), 32'h0};
            tick();
            expect_out(1, 32'h8000_0000 + 32'(k * 4), 1'b0, 1'b1);
        end
        out_ready = 2'b01;
        flush     = 1'b1;
        tick();
        flush     = 1'b0;
        in_valid  = 2'b00;
        out_ready = 2'b11;
        check("miss_flush_clears", out_valid[1], 1'b0);
`ifdef ADDR_TRANS_PIPE_MISS_CNT_EN
        check("miss_cnt_ch1_total", miss_cnt[63:32], 32'd5);
        check("miss_cnt_ch0_total", miss_cnt[31:0], 32'd0);
`endif
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
